// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared select encoding and default width for the 4:1 selector
package mux4_pkg;

    typedef enum logic [1:0] {
        SEL_D0 = 2'b00,
        SEL_D1 = 2'b01,
        SEL_D2 = 2'b10,
        SEL_D3 = 2'b11
    } mux4_sel_e;

    localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux4_core.sv
// rtl/mux4_core.sv - combinational WIDTH-bit 4:1 word select, no clock
module mux4_core
    import mux4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] z
);

    // Default branch only fires on X/Z select in simulation; it keeps the case full.
    always_comb begin
        z = '0;
        case (mux4_sel_e'(sel))
            SEL_D0:  z = d0;
            SEL_D1:  z = d1;
            SEL_D2:  z = d2;
            SEL_D3:  z = d3;
            default: z = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - 4:1 selector with combinational and registered outputs; MUX4_PARITY_EN adds registered parity z_par
module mux_4to1
    import mux4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
`ifdef MUX4_PARITY_EN
    output logic             z_par,
`endif
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_q
);

    logic [WIDTH-1:0] z_d;

    mux4_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (sel),
        .z   (z_d)
    );

    assign z = z_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

`ifdef MUX4_PARITY_EN
    logic par_d;
    logic par_q;

    always_comb begin
        par_d = ^z_d;
    end

    // Parity tracks z_q exactly because both load from the same z_d sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign z_par = par_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// tb/tb_mux_4to1.sv - self-checking bench for mux_4to1 (WIDTH 1 and 8, MUX4_PARITY_EN aware)
module tb_mux_4to1;

    logic       clk;
    logic       rst;

    logic       a0, a1, a2, a3;
    logic [1:0] asel;
    logic       az, az_q;

    logic [7:0] b0, b1, b2, b3;
    logic [1:0] bsel;
    logic [7:0] bz, bz_q;
`ifdef MUX4_PARITY_EN
    logic       a_par, b_par;
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .d0    (a0),
        .d1    (a1),
        .d2    (a2),
        .d3    (a3),
        .sel   (asel),
`ifdef MUX4_PARITY_EN
        .z_par (a_par),
`endif
        .z     (az),
        .z_q   (az_q)
    );

    mux_4to1 #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .d0    (b0),
        .d1    (b1),
        .d2    (b2),
        .d3    (b3),
        .sel   (bsel),
`ifdef MUX4_PARITY_EN
        .z_par (b_par),
`endif
        .z     (bz),
        .z_q   (bz_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sel(input logic [7:0] w [4], input int s);
        return w[s];
    endfunction

    initial begin
        logic [3:0]  tbl_d [8];
        logic [1:0]  tbl_s [8];
        logic        tbl_z [8];
        logic [23:0] v0, v1, v2, v3, vs1, vs0, vexp;
        logic [7:0]  words [4];
        logic [7:0]  exp_now, exp_reg;
        int          s;

        rst = 1'b1;
        {a0, a1, a2, a3} = 4'b0;
        asel = 2'b00;
        {b0, b1, b2, b3} = 32'h0;
        bsel = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        check("reset_zq_w1", {31'b0, az_q}, 32'd0);
        check("reset_zq_w8", {24'b0, bz_q}, 32'd0);
`ifdef MUX4_PARITY_EN
        check("reset_par", {31'b0, b_par}, 32'd0);
`endif
        rst = 1'b0;

        // table entries as {d0,d1,d2,d3}
        tbl_d = '{4'b0111, 4'b1000, 4'b1101, 4'b0011, 4'b0010, 4'b1101, 4'b1110, 4'b0001};
        tbl_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        tbl_z = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            {a0, a1, a2, a3} = tbl_d[i];
            asel = tbl_s[i];
            #0.5;
            check($sformatf("exh_%0d", i), {31'b0, az}, {31'b0, tbl_z[i]});
        end

        v0 = 24'h572583; v1 = 24'hE38DE5; v2 = 24'h592CA9; v3 = 24'hA8CB6C;
        vs1 = 24'h000FFF; vs0 = 24'h03F03F; vexp = 24'h578CAC;
        for (int i = 0; i < 24; i++) begin
            a0 = v0[i]; a1 = v1[i]; a2 = v2[i]; a3 = v3[i];
            asel = {vs1[i], vs0[i]};
            #0.5;
            check($sformatf("reg24_%0d", i), {31'b0, az}, {31'b0, vexp[i]});
        end

        b0 = 8'h11; b1 = 8'h22; b2 = 8'h33; b3 = 8'h44; bsel = 2'd0;
        @(posedge clk); #1;
        check("lat_zq_before", {24'b0, bz_q}, 32'h11);
        bsel = 2'd3;
        #1;
        check("lat_z_now", {24'b0, bz}, 32'h44);
        check("lat_zq_hold", {24'b0, bz_q}, 32'h11);
        @(posedge clk); #1;
        check("lat_zq_after", {24'b0, bz_q}, 32'h44);

        bsel = 2'd2; b2 = 8'hFF; rst = 1'b1;
        @(posedge clk); #1;
        check("rst_z", {24'b0, bz}, 32'hFF);
        check("rst_zq_1", {24'b0, bz_q}, 32'h00);
        @(posedge clk); #1;
        check("rst_zq_2", {24'b0, bz_q}, 32'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release", {24'b0, bz_q}, 32'hFF);

`ifdef MUX4_PARITY_EN
        bsel = 2'd0; b0 = 8'h07;
        @(posedge clk); #1;
        check("par_07", {31'b0, b_par}, 32'd1);
        b0 = 8'h03;
        @(posedge clk); #1;
        check("par_03", {31'b0, b_par}, 32'd0);
        b0 = 8'h01;
        @(posedge clk); #1;
        check("par_01", {31'b0, b_par}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("par_rst", {31'b0, b_par}, 32'd0);
        rst = 1'b0;
`endif

        b0 = 8'hA5; b1 = 8'h5A; b2 = 8'hC3; b3 = 8'h3C; bsel = 2'd1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_z", {24'b0, bz}, 32'h5A);
            check("hold_zq", {24'b0, bz_q}, 32'h5A);
            check("hold_eq", {24'b0, bz_q}, {24'b0, bz});
        end

        // random traffic against a word-array model with occasional reset
        exp_reg = bz_q;
        exp_now = bz;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            words[0] = 8'($urandom); words[1] = 8'($urandom);
            words[2] = 8'($urandom); words[3] = 8'($urandom);
            s = $urandom_range(0, 3);
            b0 = words[0]; b1 = words[1]; b2 = words[2]; b3 = words[3];
            bsel = 2'(s);
            exp_now = ref_sel(words, s);
            #1;
            check("rand_z", {24'b0, bz}, {24'b0, exp_now});
            exp_reg = rst ? 8'h00 : exp_now;
            @(posedge clk); #1;
            check("rand_zq", {24'b0, bz_q}, {24'b0, exp_reg});
`ifdef MUX4_PARITY_EN
            check("rand_par", {31'b0, b_par}, {31'b0, ^exp_reg});
`endif
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
4:1 selector; picks one of four WIDTH-bit data inputs by a 2-bit select.
- Combinational output z has zero latency and is the primary result.
- Registered copy z_q is one clock later, for timing-critical consumers.
- Leaf datapath primitive used wherever a 4-way data choice is needed.

Parameters:
WIDTH, 1, bit width of each data input and of z / z_q.

Ports:
clk  input  1  rising-edge clock; drives z_q only.
rst  input  1  synchronous, active-high reset; clears z_q.
d0  input  WIDTH  data input, selected when sel == 2'b00.
d1  input  WIDTH  data input, selected when sel == 2'b01.
d2  input  WIDTH  data input, selected when sel == 2'b10.
d3  input  WIDTH  data input, selected when sel == 2'b11.
sel  input  2  select; sel[1] is the MSB.
z  output  WIDTH  combinational selected data.
z_q  output  WIDTH  registered selected data.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- z is purely combinational: z = d0/d1/d2/d3 for sel = 0/1/2/3.
  - Zero latency; z settles within the same delta/propagation time as any input change.
  - z is unaffected by clk and rst.
- z_q on each rising clk edge:
  - rst = 1 → z_q <= '0.
  - otherwise → z_q <= the value of z sampled at that edge.
  - Latency: exactly 1 cycle after inputs are stable before the edge.
- z_q reset value: all zeros. z has no reset value; it always follows the inputs.
- Reset mid-operation: z_q clears at the first edge with rst = 1 and holds 0 while rst is high. At the first edge with rst = 0 it loads the current z.
- Unknown sel bits (X/Z) in simulation: z is driven to all-X. Synthesis must not create latches; use a full case with a default branch.
- All bits of a word are selected together; no per-bit select.
- No handshake and no state machine.

Optional Feature:
Macro MUX4_PARITY_EN.
- Defined:
  - Extra output port z_par (1 bit) is present.
  - z_par is registered: z_par <= ^z at each rising clk edge; rst clears it to 0.
  - It therefore always equals the even-parity XOR of z_q.
- Undefined: the z_par port and its flop do not exist. All other behaviour is identical.

Decomposition:
- Package mux4_pkg holds:
  - typedef enum logic [1:0] mux4_sel_e: SEL_D0 = 2'b00, SEL_D1 = 2'b01, SEL_D2 = 2'b10, SEL_D3 = 2'b11.
  - localparam DEFAULT_WIDTH = 1.
- One sub-module, mux4_core: the combinational WIDTH-bit select, with no clock.
- The top level instantiates mux4_core and adds the z_q register plus the optional parity flop.

Test Plan:
- Exhaustive select, WIDTH = 1, inputs applied as (d0, d1, d2, d3, sel):
  - (0,1,1,1,00) → z = 0.
  - (1,0,0,0,00) → z = 1.
  - (1,1,0,1,01) → z = 1.
  - (0,0,1,1,01) → z = 0.
  - (0,0,1,0,10) → z = 1.
  - (1,1,0,1,10) → z = 0.
  - (1,1,1,0,11) → z = 0.
  - (0,0,0,1,11) → z = 1.
  - All results checked without a clock edge.
- 24-vector regression, sweeping sel 11→10→01→00 in groups of six:
  - d0 = 0x572583, d1 = 0xE38DE5, d2 = 0x592CA9, d3 = 0xA8CB6C.
  - sel1 = 0x000FFF, sel0 = 0x03F03F.
  - Bit i of each vector is applied per step; z must equal bit i of 0x578CAC at every step.
- Register latency, WIDTH = 8:
  - d0..d3 = 0x11, 0x22, 0x33, 0x44; change sel 0→3 just after an edge.
  - z = 0x44 immediately; z_q = 0x11 until the next edge, then 0x44.
- Reset:
  - Hold rst = 1 across two edges with sel = 2, d2 = 0xFF → z = 0xFF, z_q = 0x00.
  - Release rst → z_q = 0xFF after the first edge.
- Parity (MUX4_PARITY_EN defined, WIDTH = 8):
  - Select 0x07 → z_par = 1 one edge later.
  - Select 0x03 → z_par = 0.
  - rst = 1 → z_par = 0.
- Hold stability: inputs constant for 10 edges → z_q and z unchanged, and z_q == z.
